// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin result-broadcast arbiter feeding the reservation stations
// Optional zero-tag checking is enabled by defining CDB_ID_CHECK_EN.
module cdb_arbiter #(
    parameter int SOURCES     = 4,
    parameter int RS_ID_WIDTH = 5,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [0:SOURCES-1]                    src_valid,
    output logic [0:SOURCES-1]                    src_ready,
    input  logic [0:SOURCES-1][0:RS_ID_WIDTH-1]   src_rs_id,
    input  logic [0:SOURCES-1][0:DATA_WIDTH-1]    src_value,
    output logic                                  operand_valid,
    output logic [RS_ID_WIDTH-1:0]                update_op_rs_id_out,
    output logic [DATA_WIDTH-1:0]                 update_op_value_out,
    output logic                                  id_error
);

    localparam int PW = (SOURCES > 1) ? $clog2(SOURCES) : 1;

    logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
    logic                   valid_q, valid_d;
    logic [RS_ID_WIDTH-1:0] tag_q, tag_d;
    logic [DATA_WIDTH-1:0]  value_q, value_d;

    logic                   grant_found;
    logic [PW-1:0]          grant_idx;
    logic [PW-1:0]          cand;
    logic                   xfer;
    logic [RS_ID_WIDTH-1:0] win_id;
    logic [DATA_WIDTH-1:0]  win_value;
    logic                   do_broadcast;

    // Scan starting at rr_ptr; the first valid source in rotation order wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < SOURCES; k++) begin
            cand = PW'((int'(rr_ptr_q) + k) % SOURCES);
            if (!grant_found && src_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        src_ready = '0;
        for (int i = 0; i < SOURCES; i++) begin
            src_ready[i] = rst && grant_found && (grant_idx == PW'(i));
        end
    end

    assign xfer      = rst && grant_found;
    assign win_id    = src_rs_id[grant_idx];
    assign win_value = src_value[grant_idx];

`ifdef CDB_ID_CHECK_EN
    logic id_error_q, id_error_d;
    logic win_zero;

    assign win_zero     = (win_id == '0);
    assign do_broadcast = xfer && !win_zero;

    always_comb begin
        id_error_d = id_error_q | (xfer && win_zero);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_error_q <= 1'b0;
        end else begin
            id_error_q <= id_error_d;
        end
    end

    assign id_error = id_error_q;
`else
    assign do_broadcast = xfer;
    assign id_error     = 1'b0;
`endif

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        valid_d  = do_broadcast;
        tag_d    = tag_q;
        value_d  = value_q;
        if (xfer) begin
            rr_ptr_d = (grant_idx == PW'(SOURCES - 1)) ? '0 : grant_idx + 1'b1;
        end
        // Tag/value hold their last broadcast when nothing (legal) is sent.
        if (do_broadcast) begin
            tag_d   = win_id;
            value_d = win_value;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q <= '0;
            valid_q  <= 1'b0;
            tag_q    <= '0;
            value_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            value_q  <= value_d;
        end
    end

    assign operand_valid       = valid_q;
    assign update_op_rs_id_out = tag_q;
    assign update_op_value_out = value_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter
module tb_cdb_arbiter;

    localparam int S  = 4;
    localparam int IW = 5;
    localparam int DW = 32;

    logic                     clk;
    logic                     rst;
    logic [0:S-1]             src_valid;
    logic [0:S-1]             src_ready;
    logic [0:S-1][0:IW-1]     src_rs_id;
    logic [0:S-1][0:DW-1]     src_value;
    logic                     operand_valid;
    logic [IW-1:0]            update_op_rs_id_out;
    logic [DW-1:0]            update_op_value_out;
    logic                     id_error;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    cdb_arbiter #(.SOURCES(S), .RS_ID_WIDTH(IW), .DATA_WIDTH(DW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .src_valid           (src_valid),
        .src_ready           (src_ready),
        .src_rs_id           (src_rs_id),
        .src_value           (src_value),
        .operand_valid       (operand_valid),
        .update_op_rs_id_out (update_op_rs_id_out),
        .update_op_value_out (update_op_value_out),
        .id_error            (id_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every broadcast must match the oldest expected entry.
    always @(negedge clk) begin
        if (operand_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL unexpected_broadcast: got tag %0h value %0h expected none",
                         update_op_rs_id_out, update_op_value_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (update_op_rs_id_out !== e.id || update_op_value_out !== e.val) begin
                    n_fails++;
                    $display("FAIL broadcast: got tag %0h value %0h expected tag %0h value %0h",
                             update_op_rs_id_out, update_op_value_out, e.id, e.val);
                end
            end
        end
    end

    task automatic expect_bc(input logic [IW-1:0] id, input logic [DW-1:0] val);
        exp_t e;
        e.id  = id;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Check the combinational grant, queue the broadcast it implies, then clock it in.
    task automatic grant_step(input string name, input logic [0:S-1] mask,
                              input logic [IW-1:0] id, input logic [DW-1:0] val);
        #1;
        check(name, 64'(src_ready), 64'(mask));
        expect_bc(id, val);
        next_cycle();
    endtask

    task automatic set_src(input int i, input logic v, input logic [IW-1:0] id,
                           input logic [DW-1:0] val);
        src_valid[i] = v;
        src_rs_id[i] = id;
        src_value[i] = val;
    endtask

    initial begin
        int waited;
        rst       = 1'b0;
        src_valid = '0;
        src_rs_id = '0;
        src_value = '0;
        for (int i = 0; i < S; i++) set_src(i, 1'b1, IW'(i + 1), DW'(100 + i));
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 64'(src_ready), 64'(4'b0000));
        check("reset_valid", 64'(operand_valid), 64'(0));
        check("reset_tag", 64'(update_op_rs_id_out), 64'(0));
        check("reset_value", 64'(update_op_value_out), 64'(0));
        check("reset_id_error", 64'(id_error), 64'(0));

        @(posedge clk);
        #1;
        rst = 1'b1;
        grant_step("rot_g0", 4'b1000, 5'd1, 32'd100);
        grant_step("rot_g1", 4'b0100, 5'd2, 32'd101);
        grant_step("rot_g2", 4'b0010, 5'd3, 32'd102);
        grant_step("rot_g3", 4'b0001, 5'd4, 32'd103);
        grant_step("rot_g4", 4'b1000, 5'd1, 32'd100);
        grant_step("rot_g5", 4'b0100, 5'd2, 32'd101);
        src_valid = '0;
        next_cycle();

        set_src(2, 1'b1, 5'd5, 32'd16);
        grant_step("single_g2", 4'b0010, 5'd5, 32'd16);
        src_valid = '0;
        #1;
        check("idle_ready", 64'(src_ready), 64'(0));
        next_cycle();
        @(negedge clk);
        check("idle_valid", 64'(operand_valid), 64'(0));
        check("hold_tag", 64'(update_op_rs_id_out), 64'(5));
        check("hold_value", 64'(update_op_value_out), 64'(16));
        @(posedge clk);
        #1;

        set_src(3, 1'b1, 5'd9, 32'd33);
        grant_step("wrap_g3", 4'b0001, 5'd9, 32'd33);
        set_src(1, 1'b1, 5'd6, 32'd61);
        set_src(3, 1'b1, 5'd9, 32'd34);
        grant_step("wrap_g1", 4'b0100, 5'd6, 32'd61);
        src_valid[1] = 1'b0;
        grant_step("wrap_g3b", 4'b0001, 5'd9, 32'd34);
        src_valid = '0;

        set_src(0, 1'b1, 5'd3, 32'h30);
        set_src(1, 1'b1, 5'd7, 32'hDEADBEEF);
        grant_step("stab_g0", 4'b1000, 5'd3, 32'h30);
        grant_step("stab_g1", 4'b0100, 5'd7, 32'hDEADBEEF);
        src_valid[1] = 1'b0;
        src_value[0] = 32'h31;
        grant_step("stab_g0b", 4'b1000, 5'd3, 32'h31);
        src_valid = '0;

        set_src(0, 1'b1, 5'd0, 32'd9);
`ifdef CDB_ID_CHECK_EN
        #1;
        check("zero_ready", 64'(src_ready), 64'(4'b1000));
        next_cycle();
`else
        grant_step("zero_ready", 4'b1000, 5'd0, 32'd9);
`endif
        src_valid = '0;
        @(negedge clk);
`ifdef CDB_ID_CHECK_EN
        check("zero_id_error", 64'(id_error), 64'(1));
`else
        check("zero_id_error", 64'(id_error), 64'(0));
`endif
        @(posedge clk);
        #1;
        set_src(0, 1'b1, 5'd4, 32'd40);
        grant_step("after_zero", 4'b1000, 5'd4, 32'd40);
        src_valid = '0;
        @(negedge clk);
`ifdef CDB_ID_CHECK_EN
        check("id_error_sticky", 64'(id_error), 64'(1));
`else
        check("id_error_sticky", 64'(id_error), 64'(0));
`endif
        @(posedge clk);
        #1;

        set_src(2, 1'b1, 5'd11, 32'd77);
        #1;
        check("midrst_ready", 64'(src_ready), 64'(4'b0010));
        next_cycle();
        rst = 1'b0;
        #1;
        check("midrst_valid", 64'(operand_valid), 64'(0));
        check("midrst_id_error", 64'(id_error), 64'(0));
        check("midrst_ready0", 64'(src_ready), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_src(1, 1'b1, 5'd12, 32'd88);
        grant_step("postrst_g1", 4'b0100, 5'd12, 32'd88);
        src_valid = '0;

        waited = 0;
        while (exp_q.size() != 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        repeat (2) @(posedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
